spi_adc_capture: RTL and testbench

//  Periodically reads one conversion result from an external SPI ADC and emits it as a 32-bit
//  AXI-Stream word. Sits directly upstream of packetizer_s2mm, feeding its s_axis_data port.

---
 rtl/spi_adc_capture.sv | 217 +++++++++++++++++++++
 tb/tb_spi_adc_capture.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_adc_capture.sv
// Periodic SPI ADC reader: captures one DATA_WIDTH-bit conversion per trigger and offers it as a
// 32-bit AXI-Stream word through a single-entry output register with sticky drop detection.
module spi_adc_capture #(
  parameter int DATA_WIDTH  = 24,
  parameter int SCK_DIV     = 2,
  parameter int SIGN_EXTEND = 0
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        enable,
  input  logic [31:0] sample_period,
  output logic        spi_cs_n,
  output logic        spi_sck,
  input  logic        spi_sdo,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        overflow,
  output logic [31:0] sample_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [15:0] DIV_LAST = 16'(SCK_DIV - 1);
  localparam logic [5:0]  BIT_LAST = 6'(DATA_WIDTH - 1);

  // Keeps the low DATA_WIDTH bits of the shift register and fills the rest per SIGN_EXTEND.
  function automatic logic [31:0] extend_sample(input logic [31:0] raw);
    logic [31:0] res;
    for (int i = 0; i < 32; i++) begin
      if (i < DATA_WIDTH) begin
        res[i] = raw[i];
      end else if (SIGN_EXTEND != 0) begin
        res[i] = raw[DATA_WIDTH-1];
      end else begin
        res[i] = 1'b0;
      end
    end
    return res;
  endfunction

  state_t      state_q, state_d;
  logic        cs_n_q, cs_n_d;
  logic        sck_q, sck_d;
  logic [15:0] div_q, div_d;
  logic [5:0]  bit_q, bit_d;
  logic [31:0] shreg_q, shreg_d;
  logic [31:0] cnt_q, cnt_d;
  logic        pending_q, pending_d;
  logic [31:0] tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d;
  logic        ovf_q, ovf_d;
  logic [31:0] count_q, count_d;

  logic [31:0] period_s;
  logic        trigger_s;
  logic        start_s;
  logic        done_s;

  // Period counter, trigger generation and the single pending-trigger slot.
  always_comb begin
    period_s  = (sample_period == 32'd0) ? 32'd1 : sample_period;
    trigger_s = enable && (cnt_q == 32'd0);
    start_s   = (state_q == ST_IDLE) && enable && (trigger_s || pending_q);
    if (!enable) begin
      cnt_d = 32'd0;
    end else if (cnt_q >= period_s - 32'd1) begin
      cnt_d = 32'd0;
    end else begin
      cnt_d = cnt_q + 32'd1;
    end
    if (!enable || start_s) begin
      pending_d = 1'b0;
    end else if (trigger_s && (state_q != ST_IDLE)) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end
  end

  // Frame sequencer; cs_n/sck are produced as next-state values so the pins come straight from flops.
  always_comb begin
    state_d = state_q;
    cs_n_d  = cs_n_q;
    sck_d   = sck_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    done_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cs_n_d = 1'b1;
        sck_d  = 1'b0;
        if (start_s) begin
          state_d = ST_SETUP;
          cs_n_d  = 1'b0;
          div_d   = 16'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (div_q == DIV_LAST) begin
          state_d = ST_SHIFT;
          div_d   = 16'd0;
          bit_d   = 6'd0;
        end else begin
          div_d = div_q + 16'd1;
        end
      end
      ST_SHIFT: begin
        if (div_q != DIV_LAST) begin
          div_d = div_q + 16'd1;
        end else if (!sck_q) begin
          // Sample on the edge that raises sck: the ADC changed sdo half a bit earlier.
          div_d   = 16'd0;
          sck_d   = 1'b1;
          shreg_d = {shreg_q[30:0], spi_sdo};
        end else begin
          div_d = 16'd0;
          sck_d = 1'b0;
          if (bit_q == BIT_LAST) begin
            state_d = ST_DONE;
            cs_n_d  = 1'b1;
          end else begin
            bit_d = bit_q + 6'd1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cs_n_d  = 1'b1;
        sck_d   = 1'b0;
        done_s  = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        cs_n_d  = 1'b1;
        sck_d   = 1'b0;
      end
    endcase
  end

  // Output register, drop detection and accepted-word counter.
  always_comb begin
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    ovf_d    = ovf_q;
    count_d  = count_q;
    if (tvalid_q && m_axis_tready) begin
      tvalid_d = 1'b0;
      count_d  = count_q + 32'd1;
    end else begin
      tvalid_d = tvalid_q;
    end
    if (done_s) begin
      if (!tvalid_q || m_axis_tready) begin
        tdata_d  = extend_sample(shreg_q);
        tvalid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else begin
      ovf_d = ovf_q;
    end
    if (!enable) begin
      ovf_d   = 1'b0;
      count_d = 32'd0;
    end else begin
      count_d = count_d;
    end
  end

  // State and output registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= ST_IDLE;
      cs_n_q    <= 1'b1;
      sck_q     <= 1'b0;
      div_q     <= 16'd0;
      bit_q     <= 6'd0;
      shreg_q   <= 32'd0;
      cnt_q     <= 32'd0;
      pending_q <= 1'b0;
      tdata_q   <= 32'd0;
      tvalid_q  <= 1'b0;
      ovf_q     <= 1'b0;
      count_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      cs_n_q    <= cs_n_d;
      sck_q     <= sck_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      ovf_q     <= ovf_d;
      count_q   <= count_d;
    end
  end

  assign spi_cs_n      = cs_n_q;
  assign spi_sck       = sck_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign overflow      = ovf_q;
  assign sample_count  = count_q;

endmodule

// File: tb/tb_spi_adc_capture.sv
// Directed bench for spi_adc_capture: default instance (a) plus a SIGN_EXTEND=1, SCK_DIV=1 instance (b),
// each driven by a behavioural SPI ADC that shifts a 24-bit word MSB first on falling sck.
module tb_spi_adc_capture;

  logic        aclk = 1'b0;
  logic        aresetn;
  int          checks = 0;
  int          failures = 0;

  logic        en_a, cs_a, sck_a, sdo_a, tvalid_a, tready_a, ovf_a;
  logic [31:0] per_a, tdata_a, cnt_a;
  logic [23:0] word_a, sreg_a;
  logic        en_b, cs_b, sck_b, sdo_b, tvalid_b, tready_b, ovf_b;
  logic [31:0] per_b, tdata_b, cnt_b;
  logic [23:0] word_b, sreg_b;

  always #5 aclk = ~aclk;

  spi_adc_capture dut_a (
    .aclk(aclk), .aresetn(aresetn), .enable(en_a), .sample_period(per_a),
    .spi_cs_n(cs_a), .spi_sck(sck_a), .spi_sdo(sdo_a),
    .m_axis_tdata(tdata_a), .m_axis_tvalid(tvalid_a), .m_axis_tready(tready_a),
    .overflow(ovf_a), .sample_count(cnt_a)
  );

  spi_adc_capture #(.DATA_WIDTH(24), .SCK_DIV(1), .SIGN_EXTEND(1)) dut_b (
    .aclk(aclk), .aresetn(aresetn), .enable(en_b), .sample_period(per_b),
    .spi_cs_n(cs_b), .spi_sck(sck_b), .spi_sdo(sdo_b),
    .m_axis_tdata(tdata_b), .m_axis_tvalid(tvalid_b), .m_axis_tready(tready_b),
    .overflow(ovf_b), .sample_count(cnt_b)
  );

  // ADC model for instance a: load word on cs_n fall, advance one bit per falling sck.
  initial begin
    sdo_a = 1'b0;
    forever begin
      @(negedge cs_a);
      sreg_a = word_a;
      sdo_a  = sreg_a[23];
      while (cs_a == 1'b0) begin
        @(negedge sck_a or posedge cs_a);
        if (cs_a == 1'b0) begin
          sreg_a = {sreg_a[22:0], 1'b0};
          sdo_a  = sreg_a[23];
        end
      end
    end
  end

  // ADC model for instance b.
  initial begin
    sdo_b = 1'b0;
    forever begin
      @(negedge cs_b);
      sreg_b = word_b;
      sdo_b  = sreg_b[23];
      while (cs_b == 1'b0) begin
        @(negedge sck_b or posedge cs_b);
        if (cs_b == 1'b0) begin
          sreg_b = {sreg_b[22:0], 1'b0};
          sdo_b  = sreg_b[23];
        end
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic quiesce();
    en_a = 1'b0;
    tready_a = 1'b1;
    repeat (120) tick();
    tready_a = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    en_a = 1'b0; per_a = 32'd200; tready_a = 1'b0; word_a = 24'h000000;
    en_b = 1'b0; per_b = 32'd200; tready_b = 1'b0; word_b = 24'h000000;
    repeat (3) tick();
    aresetn = 1'b1;
    tick();
    checks++; if (cs_a !== 1'b1) begin failures++; $display("FAIL reset_cs_n: got %b expected 1", cs_a); end
    checks++; if (sck_a !== 1'b0) begin failures++; $display("FAIL reset_sck: got %b expected 0", sck_a); end
    checks++; if (tvalid_a !== 1'b0) begin failures++; $display("FAIL reset_tvalid: got %b expected 0", tvalid_a); end
    checks++; if (tdata_a !== 32'h0) begin failures++; $display("FAIL reset_tdata: got %h expected 00000000", tdata_a); end
    checks++; if (ovf_a !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b expected 0", ovf_a); end
    checks++; if (cnt_a !== 32'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", cnt_a); end
  endtask

  task automatic test_basic();
    int t_cs = -1, t_sck = -1, t_v = -1, t_v2 = -1;
    word_a = 24'hA5C30F; per_a = 32'd200; tready_a = 1'b0; en_a = 1'b1;
    for (int t = 1; t <= 150; t++) begin
      tick();
      if (t_cs < 0 && cs_a === 1'b0) t_cs = t;
      if (t_sck < 0 && sck_a === 1'b1) t_sck = t;
      if (t_v < 0 && tvalid_a === 1'b1) t_v = t;
    end
    checks++; if (t_cs != 1) begin failures++; $display("FAIL basic_cs_fall_tick: got %0d expected 1", t_cs); end
    checks++; if (t_sck != 5) begin failures++; $display("FAIL basic_first_sck_rise_tick: got %0d expected 5", t_sck); end
    checks++; if (t_v != 100) begin failures++; $display("FAIL basic_tvalid_tick: got %0d expected 100", t_v); end
    checks++; if (tdata_a !== 32'h00A5C30F) begin failures++; $display("FAIL basic_tdata: got %h expected 00a5c30f", tdata_a); end
    checks++; if (cnt_a !== 32'd0) begin failures++; $display("FAIL basic_count_before_accept: got %0d expected 0", cnt_a); end
    tready_a = 1'b1;
    tick();
    tready_a = 1'b0;
    checks++; if (tvalid_a !== 1'b0) begin failures++; $display("FAIL basic_tvalid_after_accept: got %b expected 0", tvalid_a); end
    checks++; if (cnt_a !== 32'd1) begin failures++; $display("FAIL basic_count_after_accept: got %0d expected 1", cnt_a); end
    for (int t = 152; t <= 320; t++) begin
      tick();
      if (t_v2 < 0 && tvalid_a === 1'b1) t_v2 = t;
    end
    checks++; if (t_v2 != 300) begin failures++; $display("FAIL basic_second_word_tick: got %0d expected 300", t_v2); end
    checks++; if (tdata_a !== 32'h00A5C30F) begin failures++; $display("FAIL basic_second_tdata: got %h expected 00a5c30f", tdata_a); end
    quiesce();
  endtask

  task automatic test_back_to_back();
    int last = -1, first = -1, pulses = 0, run = 0;
    word_a = 24'h123456; per_a = 32'd10; tready_a = 1'b1; en_a = 1'b1;
    for (int t = 1; t <= 510; t++) begin
      tick();
      if (tvalid_a === 1'b1) begin
        pulses++;
        if (first < 0) first = t;
        if (last >= 0) begin
          checks++; if (t - last != 100) begin failures++; $display("FAIL b2b_gap: got %0d expected 100", t - last); end
        end
        last = t;
        checks++; if (tdata_a !== 32'h00123456) begin failures++; $display("FAIL b2b_tdata: got %h expected 00123456", tdata_a); end
      end
      if (cs_a === 1'b1) begin
        run++;
      end else begin
        if (run > 0) begin
          checks++; if (run != 2) begin failures++; $display("FAIL b2b_cs_high_cycles: got %0d expected 2", run); end
        end
        run = 0;
      end
    end
    checks++; if (first != 100) begin failures++; $display("FAIL b2b_first_tick: got %0d expected 100", first); end
    checks++; if (pulses != 5) begin failures++; $display("FAIL b2b_pulses: got %0d expected 5", pulses); end
    checks++; if (cnt_a !== 32'd5) begin failures++; $display("FAIL b2b_count: got %0d expected 5", cnt_a); end
    per_a = 32'd200;
    quiesce();
  endtask

  task automatic test_overflow();
    word_a = 24'h111111; per_a = 32'd200; tready_a = 1'b0; en_a = 1'b1;
    repeat (100) tick();
    checks++; if (tvalid_a !== 1'b1) begin failures++; $display("FAIL ovf_first_valid: got %b expected 1", tvalid_a); end
    word_a = 24'h222222;
    repeat (150) tick();
    checks++; if (ovf_a !== 1'b0) begin failures++; $display("FAIL ovf_before_second_frame: got %b expected 0", ovf_a); end
    repeat (55) tick();
    checks++; if (ovf_a !== 1'b1) begin failures++; $display("FAIL ovf_after_second_frame: got %b expected 1", ovf_a); end
    checks++; if (tdata_a !== 32'h00111111) begin failures++; $display("FAIL ovf_held_word: got %h expected 00111111", tdata_a); end
    repeat (200) tick();
    checks++; if (tdata_a !== 32'h00111111) begin failures++; $display("FAIL ovf_held_word_third: got %h expected 00111111", tdata_a); end
    checks++; if (cnt_a !== 32'd0) begin failures++; $display("FAIL ovf_count_stalled: got %0d expected 0", cnt_a); end
    tready_a = 1'b1;
    tick();
    tready_a = 1'b0;
    checks++; if (cnt_a !== 32'd1) begin failures++; $display("FAIL ovf_count_after_accept: got %0d expected 1", cnt_a); end
    checks++; if (tvalid_a !== 1'b0) begin failures++; $display("FAIL ovf_tvalid_after_accept: got %b expected 0", tvalid_a); end
    checks++; if (ovf_a !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b expected 1", ovf_a); end
    en_a = 1'b0;
    tick();
    checks++; if (ovf_a !== 1'b0) begin failures++; $display("FAIL ovf_cleared_by_disable: got %b expected 0", ovf_a); end
    checks++; if (cnt_a !== 32'd0) begin failures++; $display("FAIL ovf_count_cleared: got %0d expected 0", cnt_a); end
    quiesce();
  endtask

  task automatic test_enable_drop();
    int words = 0, t_v = -1, late_cs = 0;
    word_a = 24'h0F0F0F; per_a = 32'd200; tready_a = 1'b1; en_a = 1'b1;
    repeat (50) tick();
    en_a = 1'b0;
    for (int t = 51; t <= 450; t++) begin
      tick();
      if (tvalid_a === 1'b1) begin
        words++;
        t_v = t;
        checks++; if (tdata_a !== 32'h000F0F0F) begin failures++; $display("FAIL drop_tdata: got %h expected 000f0f0f", tdata_a); end
      end
      if (t > 100 && cs_a !== 1'b1) late_cs++;
    end
    checks++; if (words != 1) begin failures++; $display("FAIL drop_word_count: got %0d expected 1", words); end
    checks++; if (t_v != 100) begin failures++; $display("FAIL drop_word_tick: got %0d expected 100", t_v); end
    checks++; if (late_cs != 0) begin failures++; $display("FAIL drop_cs_activity: got %0d expected 0", late_cs); end
    checks++; if (cnt_a !== 32'd0) begin failures++; $display("FAIL drop_count_zero: got %0d expected 0", cnt_a); end
    checks++; if (ovf_a !== 1'b0) begin failures++; $display("FAIL drop_overflow_zero: got %b expected 0", ovf_a); end
    quiesce();
  endtask

  task automatic test_reset_mid();
    int t_v = -1;
    logic [31:0] got = 32'h0;
    word_a = 24'hABCDEF; per_a = 32'd200; tready_a = 1'b0; en_a = 1'b1;
    repeat (50) tick();
    checks++; if (sck_a !== 1'b1) begin failures++; $display("FAIL rst_mid_sck_high: got %b expected 1", sck_a); end
    #2 aresetn = 1'b0;
    #1;
    checks++; if (cs_a !== 1'b1) begin failures++; $display("FAIL rst_mid_cs_n: got %b expected 1", cs_a); end
    checks++; if (sck_a !== 1'b0) begin failures++; $display("FAIL rst_mid_sck: got %b expected 0", sck_a); end
    word_a = 24'h5A5A5A;
    @(negedge aclk);
    aresetn = 1'b1;
    for (int t = 1; t <= 150; t++) begin
      tick();
      if (t_v < 0 && tvalid_a === 1'b1) begin
        t_v = t;
        got = tdata_a;
      end
    end
    checks++; if (t_v != 100) begin failures++; $display("FAIL rst_mid_fresh_tick: got %0d expected 100", t_v); end
    checks++; if (got !== 32'h005A5A5A) begin failures++; $display("FAIL rst_mid_fresh_tdata: got %h expected 005a5a5a", got); end
    quiesce();
  endtask

  task automatic test_sign_extend();
    int t_v = -1, t_v2 = -1;
    word_b = 24'h800001; per_b = 32'd200; tready_b = 1'b0; en_b = 1'b1;
    for (int t = 1; t <= 80; t++) begin
      tick();
      if (t_v < 0 && tvalid_b === 1'b1) t_v = t;
    end
    checks++; if (t_v != 51) begin failures++; $display("FAIL sext_tvalid_tick: got %0d expected 51", t_v); end
    checks++; if (tdata_b !== 32'hFF800001) begin failures++; $display("FAIL sext_negative: got %h expected ff800001", tdata_b); end
    word_b = 24'h7FFFFF;
    tready_b = 1'b1;
    tick();
    tready_b = 1'b0;
    checks++; if (cnt_b !== 32'd1) begin failures++; $display("FAIL sext_count: got %0d expected 1", cnt_b); end
    for (int t = 82; t <= 260; t++) begin
      tick();
      if (t_v2 < 0 && tvalid_b === 1'b1) t_v2 = t;
    end
    checks++; if (t_v2 != 251) begin failures++; $display("FAIL sext_second_tick: got %0d expected 251", t_v2); end
    checks++; if (tdata_b !== 32'h007FFFFF) begin failures++; $display("FAIL sext_positive: got %h expected 007fffff", tdata_b); end
    en_b = 1'b0;
    tready_b = 1'b1;
    repeat (5) tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_enable_drop();
    test_reset_mid();
    test_sign_extend();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
